// File: rtl/strip_frame_arbiter.sv
// strip_frame_arbiter
//   Shares one synchronous-read frame RAM port among NUM_CH LED strip drivers.
//   It arbitrates round-robin at one read per cycle. It also manages the
//   double-buffered display bank. The bank swap waits until the strips are
//   idle and no read is in flight.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   req          per-channel read request (level, held until gnt seen)
//   req_addr     per-channel byte address, channel i at [i*CH_ADDR_W +: CH_ADDR_W]
//   gnt          one-hot grant pulse, aligned with mem_addr
//   rvalid       one-hot read-valid pulse, two cycles after gnt
//   rdata        read byte, qualified by rvalid
//   mem_addr     frame RAM address {bank, channel, byte}
//   mem_dout     frame RAM read data (one-cycle latency)
//   swap_req     pulse: back buffer complete
//   frame_idle   level: all strips in latch period
//   disp_bank    bank currently displayed
//   swap_ack     pulse on the cycle disp_bank toggles
//   frame_count  completed swaps, wraps at 256

module strip_frame_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int CH_ADDR_W  = 10,
  parameter int MEM_ADDR_W = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             req,
  input  logic [NUM_CH*CH_ADDR_W-1:0]   req_addr,
  output logic [NUM_CH-1:0]             gnt,
  output logic [NUM_CH-1:0]             rvalid,
  output logic [7:0]                    rdata,
  output logic [MEM_ADDR_W-1:0]         mem_addr,
  input  logic [7:0]                    mem_dout,
  input  logic                          swap_req,
  input  logic                          frame_idle,
  output logic                          disp_bank,
  output logic                          swap_ack,
  output logic [7:0]                    frame_count
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]    elig;
  logic [NUM_CH-1:0]    gnt_nxt;
  logic [NUM_CH-1:0]    rd_pipe;
  logic [CH_W-1:0]      ptr;
  logic [CH_W-1:0]      sel;
  logic [CH_W-1:0]      cand;
  logic                 found;
  logic [CH_ADDR_W-1:0] sel_addr;
  logic                 swap_pending;
  logic                 swap_go;

  always_comb begin
    // The channel granted this cycle sits out the next decision, so a held
    // request cannot be granted twice for one access.
    elig  = req & ~gnt;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    // The candidate index wraps naturally because NUM_CH is a power of two.
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ptr + CH_W'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    gnt_nxt  = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (found && (sel == CH_W'(i))) begin
        gnt_nxt[i] = 1'b1;
        sel_addr   = req_addr[i*CH_ADDR_W +: CH_ADDR_W];
      end
    end

    // A grant on this edge, or one showing now, blocks the swap. The earliest
    // swap_ack is therefore two cycles after a visible grant. The bank bit in
    // an issued address is never contradicted by a swap on the same edge.
    swap_go = swap_pending & frame_idle & ~found & ~(|gnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt          <= '0;
      rvalid       <= '0;
      rd_pipe      <= '0;
      rdata        <= '0;
      mem_addr     <= '0;
      ptr          <= '0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      disp_bank    <= 1'b0;
      frame_count  <= '0;
    end else begin
      gnt <= gnt_nxt;
      if (found) begin
        mem_addr <= {disp_bank, sel, sel_addr};
        ptr      <= sel + CH_W'(1);
      end

      // gnt (T) -> RAM output (T+1) -> rdata/rvalid (T+2)
      rd_pipe <= gnt;
      rvalid  <= rd_pipe;
      if (|rd_pipe) begin
        rdata <= mem_dout;
      end

      swap_ack <= swap_go;
      if (swap_go) begin
        disp_bank   <= ~disp_bank;
        frame_count <= frame_count + 8'd1;
      end
      // A swap_req arriving with the swap re-arms the pending flag.
      swap_pending <= swap_req | (swap_pending & ~swap_go);
    end
  end

endmodule

// File: tb/tb_strip_frame_arbiter.sv
// Directed bench for strip_frame_arbiter. A behavioral synchronous RAM
// returns a fixed function of the address, so every expected byte is known.

module tb_strip_frame_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [39:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic [12:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        swap_req;
  logic        frame_idle;
  logic        disp_bank;
  logic        swap_ack;
  logic [7:0]  frame_count;

  int n_vec;
  int n_err;

  strip_frame_arbiter #(
    .NUM_CH(4), .CH_ADDR_W(10), .MEM_ADDR_W(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .swap_req(swap_req), .frame_idle(frame_idle),
    .disp_bank(disp_bank), .swap_ack(swap_ack), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_f(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  always @(posedge clk) mem_dout <= ram_f(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; swap_req = 1'b0; frame_idle = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Addresses used with all four channels requesting, and the expected
  // mem_addr for each with bank 0: {0, ch[1:0], addr}.
  logic [9:0]  ch_addr [4];
  logic [12:0] exp_ma  [4];

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req = '0; req_addr = '0; swap_req = 1'b0; frame_idle = 1'b0;
    ch_addr = '{10'h001, 10'h012, 10'h023, 10'h034};
    exp_ma  = '{13'h0001, 13'h0412, 13'h0823, 13'h0C34};

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_disp_bank", 32'(disp_bank), 0);
    chk("rst_swap_ack", 32'(swap_ack), 0);
    chk("rst_frame_count", 32'(frame_count), 0);

    // Single request on channel 2
    req_addr[20 +: 10] = 10'h05A;
    req = 4'b0100;
    tick();
    chk("ch2_gnt", 32'(gnt), 32'h4);
    chk("ch2_mem_addr", 32'(mem_addr), 32'h085A);
    req = '0;
    tick();
    chk("ch2_gnt_drop", 32'(gnt), 0);
    chk("ch2_rvalid_t1", 32'(rvalid), 0);
    chk("ch2_addr_hold", 32'(mem_addr), 32'h085A);
    tick();
    chk("ch2_rvalid", 32'(rvalid), 32'h4);
    chk("ch2_rdata", 32'(rdata), 32'h52);
    tick();
    chk("ch2_rvalid_end", 32'(rvalid), 0);

    // All channels requesting continuously, fresh from reset
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*10 +: 10] = ch_addr[i];
    req = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << ((k-1) % 4));
      chk("rr_mem_addr", 32'(mem_addr), 32'(exp_ma[(k-1) % 4]));
      if (k >= 3) begin
        chk("rr_rvalid", 32'(rvalid), 32'(1) << ((k-3) % 4));
        chk("rr_rdata", 32'(rdata), 32'(ram_f(exp_ma[(k-3) % 4])));
      end else begin
        chk("rr_rvalid_lead", 32'(rvalid), 0);
      end
    end
    req = '0;
    tick();
    chk("rr_gnt_idle", 32'(gnt), 0);
    chk("rr_rvalid_9", 32'(rvalid), 32'h4);
    chk("rr_rdata_9", 32'(rdata), 32'(ram_f(13'h0823)));
    tick();
    chk("rr_rvalid_10", 32'(rvalid), 32'h8);
    chk("rr_rdata_10", 32'(rdata), 32'(ram_f(13'h0C34)));
    tick();
    chk("rr_rvalid_end", 32'(rvalid), 0);

    // Swap waits for frame_idle
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (100) tick();
    chk("sw_wait_bank", 32'(disp_bank), 0);
    chk("sw_wait_ack", 32'(swap_ack), 0);
    chk("sw_wait_count", 32'(frame_count), 0);
    frame_idle = 1'b1;
    tick();
    chk("sw_ack", 32'(swap_ack), 1);
    chk("sw_bank", 32'(disp_bank), 1);
    chk("sw_count", 32'(frame_count), 1);
    tick();
    chk("sw_ack_end", 32'(swap_ack), 0);
    chk("sw_bank_hold", 32'(disp_bank), 1);

    // Coalesced swap_req plus one coincident with the swap
    do_reset();
    for (int p = 0; p < 3; p++) begin
      swap_req = 1'b1; tick();
      swap_req = 1'b0; tick();
    end
    chk("co_no_swap", 32'(frame_count), 0);
    frame_idle = 1'b1;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("co_ack1", 32'(swap_ack), 1);
    chk("co_count1", 32'(frame_count), 1);
    tick();
    chk("co_ack2", 32'(swap_ack), 1);
    chk("co_count2", 32'(frame_count), 2);
    chk("co_bank2", 32'(disp_bank), 0);
    tick();
    tick();
    chk("co_ack_end", 32'(swap_ack), 0);
    chk("co_count_final", 32'(frame_count), 2);

    // Grant to channel 1 defers a pending swap; read uses old bank
    frame_idle = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    frame_idle = 1'b1;
    req = 4'b0010;
    tick();
    chk("df_gnt", 32'(gnt), 32'h2);
    chk("df_mem_addr", 32'(mem_addr), 32'h0412);
    chk("df_ack_t", 32'(swap_ack), 0);
    req = '0;
    tick();
    chk("df_ack_t1", 32'(swap_ack), 0);
    chk("df_bank_t1", 32'(disp_bank), 0);
    tick();
    chk("df_ack_t2", 32'(swap_ack), 1);
    chk("df_bank_t2", 32'(disp_bank), 1);
    chk("df_rvalid", 32'(rvalid), 32'h2);
    chk("df_rdata", 32'(rdata), 32'(ram_f(13'h0412)));

    // Reset one cycle after a grant discards the read and the pending swap
    tick();
    frame_idle = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    req = 4'b0100;
    tick();
    chk("rg_gnt", 32'(gnt), 32'h4);
    chk("rg_mem_addr", 32'(mem_addr), 32'h1823);
    rst_n = 1'b0;
    req = '0;
    tick();
    chk("rg_gnt0", 32'(gnt), 0);
    chk("rg_rvalid0", 32'(rvalid), 0);
    chk("rg_rdata0", 32'(rdata), 0);
    chk("rg_mem_addr0", 32'(mem_addr), 0);
    chk("rg_bank0", 32'(disp_bank), 0);
    chk("rg_count0", 32'(frame_count), 0);
    chk("rg_ack0", 32'(swap_ack), 0);
    rst_n = 1'b1;
    frame_idle = 1'b1;
    tick();
    chk("rg_rvalid1", 32'(rvalid), 0);
    chk("rg_ack1", 32'(swap_ack), 0);
    tick();
    chk("rg_rvalid2", 32'(rvalid), 0);
    chk("rg_ack2", 32'(swap_ack), 0);
    chk("rg_bank2", 32'(disp_bank), 0);
    req = 4'b1111;
    tick();
    chk("rg_first_gnt", 32'(gnt), 32'h1);
    chk("rg_first_addr", 32'(mem_addr), 32'h0001);
    req = '0;
    tick();
    tick();
    chk("rg_first_rvalid", 32'(rvalid), 32'h1);
    chk("rg_first_rdata", 32'(rdata), 32'h01);

    // frame_count wraps 255 -> 0
    do_reset();
    frame_idle = 1'b1;
    swap_req = 1'b1;
    repeat (256) tick();
    chk("wr_count255", 32'(frame_count), 255);
    chk("wr_ack", 32'(swap_ack), 1);
    tick();
    chk("wr_count0", 32'(frame_count), 0);
    chk("wr_bank", 32'(disp_bank), 0);
    swap_req = 1'b0;
    tick();
    chk("wr_count1", 32'(frame_count), 1);
    tick();
    chk("wr_ack_end", 32'(swap_ack), 0);
    chk("wr_count_hold", 32'(frame_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
